// File: rtl/gnrl_fifo_pkg.sv
// Shared defaults for the general-purpose FIFO slice.
package gnrl_fifo_pkg;
   localparam int GNRL_FIFO_DW_DEF = 32;
   localparam int GNRL_FIFO_DP_DEF = 4;
endpackage

// File: rtl/gnrl_dffl.sv
// Load-enabled flop bank without reset, used for storage that is never read before written.
module gnrl_dffl #(
   parameter int W = 1
) (
   input  logic         clk,
   input  logic         lden_i,
   input  logic [W-1:0] d_i,
   output logic [W-1:0] q_o
);
   logic [W-1:0] q_q;

   always_ff @(posedge clk) begin
      if (lden_i) begin
         q_q <= d_i;
      end
   end

   assign q_o = q_q;
endmodule

// File: rtl/gnrl_dfflr.sv
// Load-enabled flop bank with asynchronous active-low clear.
module gnrl_dfflr #(
   parameter int W = 1
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         lden_i,
   input  logic [W-1:0] d_i,
   output logic [W-1:0] q_o
);
   logic [W-1:0] q_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         q_q <= '0;
      end else if (lden_i) begin
         q_q <= d_i;
      end
   end

   assign q_o = q_q;
endmodule

// File: rtl/gnrl_fifo.sv
// Synchronous first-word-fall-through FIFO; pointers carry one extra wrap bit
// so full and empty are told apart without a separate counter register.
module gnrl_fifo
   import gnrl_fifo_pkg::*;
#(
   parameter int DW = GNRL_FIFO_DW_DEF,
   parameter int DP = GNRL_FIFO_DP_DEF
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   i_vld,
   output logic                   i_rdy,
   input  logic [DW-1:0]          i_dat,
   output logic                   o_vld,
   input  logic                   o_rdy,
   output logic [DW-1:0]          o_dat,
   output logic [$clog2(DP):0]    cnt
);
   localparam int AW = $clog2(DP);

   logic [AW:0]   wptr_q;
   logic [AW:0]   wptr_d;
   logic [AW:0]   rptr_q;
   logic [AW:0]   rptr_d;
   logic          full_s;
   logic          empty_s;
   logic          push_s;
   logic          pop_s;
   logic [DW-1:0] mem_q [DP];

   assign empty_s = (wptr_q == rptr_q);
   assign full_s  = (wptr_q[AW-1:0] == rptr_q[AW-1:0]) && (wptr_q[AW] != rptr_q[AW]);

   // Handshake flags come from registered pointers only, so there is no ready/valid pass-through.
   assign i_rdy  = !full_s;
   assign o_vld  = !empty_s;
   assign push_s = i_vld && i_rdy;
   assign pop_s  = o_vld && o_rdy;

   assign wptr_d = wptr_q + {{AW{1'b0}}, 1'b1};
   assign rptr_d = rptr_q + {{AW{1'b0}}, 1'b1};

   gnrl_dfflr #(.W(AW + 1)) u_wptr (
      .clk    (clk),
      .rst_n  (rst_n),
      .lden_i (push_s),
      .d_i    (wptr_d),
      .q_o    (wptr_q)
   );

   gnrl_dfflr #(.W(AW + 1)) u_rptr (
      .clk    (clk),
      .rst_n  (rst_n),
      .lden_i (pop_s),
      .d_i    (rptr_d),
      .q_o    (rptr_q)
   );

   for (genvar e = 0; e < DP; e++) begin : g_mem
      gnrl_dffl #(.W(DW)) u_ent (
         .clk    (clk),
         .lden_i (push_s && (wptr_q[AW-1:0] == AW'(e))),
         .d_i    (i_dat),
         .q_o    (mem_q[e])
      );
   end

   assign o_dat = mem_q[rptr_q[AW-1:0]];
   // Modulo subtraction of the extended pointers yields 0..DP directly.
   assign cnt   = wptr_q - rptr_q;
endmodule
